// File: rtl/pipelined_adder_nbit.sv
// rtl/pipelined_adder_nbit.sv - pipelined N-bit add/subtract unit with valid/ready handshake
//
// Purpose:
//   Adds (Op=0: A+B+Cin) or subtracts (Op=1: A-B) WIDTH-bit operands. The operands are split
//   into STAGES chunks of CHUNK bits; each pipeline stage ripples one chunk and registers its
//   carry for the next stage. Latency is STAGES cycles, throughput one op per cycle.
//
// Ports:
//   Clk        in   1      clock, rising edge
//   Reset      in   1      synchronous, active-high reset
//   A, B       in   WIDTH  operands
//   Cin        in   1      carry in for add, ignored for subtract
//   Op         in   1      0: add, 1: subtract
//   In_valid   in   1      input operands valid
//   In_ready   out  1      input accepted this cycle when In_valid=1
//   Sum        out  WIDTH  result
//   Cout       out  1      carry out of MSB (subtract: 1 = no borrow)
//   Out_valid  out  1      Sum/Cout hold a result
//   Out_ready  in   1      sink takes the result this cycle
//   Overflow   out  1      signed overflow, present only with ADDER_OVERFLOW_EN defined
//
// Configuration macro: ADDER_OVERFLOW_EN

module pipelined_adder_nbit #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Op,
  input  logic             In_valid,
  output logic             In_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Out_valid,
  input  logic             Out_ready
`ifdef ADDER_OVERFLOW_EN
  ,
  output logic             Overflow
`endif
);

  localparam int CHUNK = WIDTH / STAGES;

  // Per-stage state: full operand copies travel down the pipe (only the bits above the
  // current chunk matter), the partial sum fills in from the bottom, carry is per stage.
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];

  // What each stage would load: stage 0 from the ports, stage k from stage k-1.
  logic [STAGES-1:0] src_v, src_c;
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];

  logic [STAGES-1:0] adv;

`ifdef ADDER_OVERFLOW_EN
  logic ovf_q, ovf_d;
`endif

  // A stage may load when it, or any stage after it, is empty, or the sink is taking the
  // output. Computed as a running AND from the output end so no bit feeds back on adv itself.
  always_comb begin : p_advance
    logic full_run;
    full_run = 1'b1;
    adv      = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full_run = full_run & valid_q[k];
      adv[k]   = Out_ready | ~full_run;
    end
  end

  always_comb begin : p_sources
    src_v    = '0;
    src_c    = '0;
    src_v[0] = In_valid;
    src_c[0] = Op ? 1'b1 : Cin;
    src_a[0] = A;
    src_b[0] = Op ? ~B : B;
    src_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = valid_q[k-1];
      src_c[k] = c_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = s_q[k-1];
    end
  end

  always_comb begin : p_stages
    logic [CHUNK:0] chunk;
    chunk   = '0;
    valid_d = valid_q;
    c_d     = c_q;
    for (int k = 0; k < STAGES; k++) begin
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      s_d[k] = s_q[k];
    end
    for (int k = 0; k < STAGES; k++) begin
      chunk = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
            + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
            + {{CHUNK{1'b0}}, src_c[k]};
      if (adv[k]) begin
        valid_d[k]                 = src_v[k];
        a_d[k]                     = src_a[k];
        b_d[k]                     = src_b[k];
        s_d[k]                     = src_s[k];
        s_d[k][k*CHUNK +: CHUNK]   = chunk[CHUNK-1:0];
        c_d[k]                     = chunk[CHUNK];
      end
    end
`ifdef ADDER_OVERFLOW_EN
    // Carry into the MSB is recovered from the MSB sum bit: c_in = a ^ b' ^ s.
    ovf_d = ovf_q;
    if (adv[STAGES-1]) begin
      ovf_d = src_a[STAGES-1][WIDTH-1] ^ src_b[STAGES-1][WIDTH-1]
            ^ s_d[STAGES-1][WIDTH-1] ^ c_d[STAGES-1];
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q <= '0;
      c_q     <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
`ifdef ADDER_OVERFLOW_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      c_q     <= c_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
`ifdef ADDER_OVERFLOW_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign In_ready  = adv[0];
  assign Out_valid = valid_q[STAGES-1];
  assign Sum       = s_q[STAGES-1];
  assign Cout      = c_q[STAGES-1];
`ifdef ADDER_OVERFLOW_EN
  assign Overflow  = ovf_q;
`endif

endmodule
